soc_timer_scheduler: RTL and testbench

//  Avalon-MM master that time-shares the single 16-bit-register interval timer among NUM_REQ
//  one-shot delay requesters. It owns the timer's s1 write port and its irq line.

---
 rtl/soc_timer_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_soc_timer_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_timer_scheduler.sv
// soc_timer_scheduler
// Time-shares one 16-bit-register interval timer among NUM_REQ one-shot delay
// requesters. A round-robin arbiter picks a requester. The block then programs
// the timer over its Avalon-MM s1 write port and waits for the timer irq. It
// finishes by clearing the timeout and reporting done or aborted to the owner.

module soc_timer_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   req_period,
    input  logic [NUM_REQ-1:0]      cancel,
    output logic [NUM_REQ-1:0]      accept,
    output logic [NUM_REQ-1:0]      done,
    output logic [NUM_REQ-1:0]      aborted,
    output logic                    busy,
    output logic [ID_W-1:0]         owner_id,
    output logic [2:0]              avm_address,
    output logic                    avm_chipselect,
    output logic                    avm_write_n,
    output logic [15:0]             avm_writedata,
    input  logic                    avm_irq
);

    // Sequencer states, one timer write per bus state except GAP and WAIT
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_CLR  = 4'd1;
    localparam logic [3:0] S_WPL  = 4'd2;
    localparam logic [3:0] S_WPH  = 4'd3;
    localparam logic [3:0] S_GAP  = 4'd4;
    localparam logic [3:0] S_WCTL = 4'd5;
    localparam logic [3:0] S_WAIT = 4'd6;
    localparam logic [3:0] S_STOP = 4'd7;
    localparam logic [3:0] S_ACK  = 4'd8;

    // Timer register indices and control words
    localparam logic [2:0]  REG_STATUS  = 3'd0;
    localparam logic [2:0]  REG_CONTROL = 3'd1;
    localparam logic [2:0]  REG_PERIODL = 3'd2;
    localparam logic [2:0]  REG_PERIODH = 3'd3;
    localparam logic [15:0] CTL_START   = 16'h0005;
    localparam logic [15:0] CTL_STOP    = 16'h0008;

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    logic [3:0]      state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [31:0]     load_q, load_d;
    logic            busy_q, busy_d;
    logic            abort_q, abort_d;

    logic            grantValid;
    logic [ID_W-1:0] grantIdx;
    logic [ID_W:0]   searchSum;
    logic [31:0]     selPeriod;

    // Round-robin search: first pending request at or above the rr pointer, with wrap
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        searchSum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            searchSum = {1'b0, rr_q} + (ID_W+1)'(k);
            if (searchSum >= NUM_REQ_W) begin
                searchSum = searchSum - NUM_REQ_W;
            end
            if (!grantValid && req[searchSum[ID_W-1:0]]) begin
                grantValid = 1'b1;
                grantIdx   = searchSum[ID_W-1:0];
            end
        end
        selPeriod = req_period[32*grantIdx +: 32];
    end

    // Next-state, pulse and bus decode; the bus idles unless a write state drives it
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rr_d           = rr_q;
        load_d         = load_q;
        busy_d         = busy_q;
        abort_d        = abort_q;
        accept         = '0;
        done           = '0;
        aborted        = '0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = 3'd0;
        avm_writedata  = 16'd0;

        case (state_q)
            S_IDLE: begin
                if (grantValid) begin
                    accept[grantIdx] = reset_n;
                    owner_d          = grantIdx;
                    load_d           = (selPeriod == 32'd0) ? 32'd0 : selPeriod - 32'd1;
                    busy_d           = 1'b1;
                    abort_d          = 1'b0;
                    state_d          = S_CLR;
                end
            end
            S_CLR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = REG_STATUS;
                state_d        = S_WPL;
            end
            S_WPL: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = REG_PERIODL;
                avm_writedata  = load_q[15:0];
                state_d        = S_WPH;
            end
            S_WPH: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = REG_PERIODH;
                avm_writedata  = load_q[31:16];
                state_d        = S_GAP;
            end
            S_GAP: begin
                state_d = S_WCTL;
            end
            S_WCTL: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = REG_CONTROL;
                avm_writedata  = CTL_START;
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                if (avm_irq) begin
                    state_d = S_ACK;
                end else if (cancel[owner_q]) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = REG_CONTROL;
                avm_writedata  = CTL_STOP;
                abort_d        = 1'b1;
                state_d        = S_ACK;
            end
            S_ACK: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = REG_STATUS;
                if (abort_q) begin
                    aborted[owner_q] = reset_n;
                end else begin
                    done[owner_q] = reset_n;
                end
                busy_d  = 1'b0;
                rr_d    = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any sequence in flight and leaves the timer alone
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            load_q  <= '0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
        end
    end

    assign busy     = busy_q;
    assign owner_id = owner_q;

endmodule

// File: tb/tb_soc_timer_scheduler.sv
// tb_soc_timer_scheduler
// Directed bench for soc_timer_scheduler with a small behavioural interval timer.

module tb_soc_timer_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam logic [20:0] BUS_IDLE = {1'b0, 1'b1, 3'd0, 16'd0};

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req;
    logic [32*NUM_REQ-1:0] req_period;
    logic [NUM_REQ-1:0]    cancel;
    logic [NUM_REQ-1:0]    accept, done, aborted;
    logic                  busy;
    logic [ID_W-1:0]       owner_id;
    logic [2:0]            avm_address;
    logic                  avm_chipselect, avm_write_n;
    logic [15:0]           avm_writedata;
    logic                  avm_irq;

    int checks = 0;
    int errors = 0;

    logic irqForce  = 1'b0;
    logic stopModel = 1'b0;

    logic [15:0] tmrPeriodL = '0;
    logic [15:0] tmrPeriodH = '0;
    logic [31:0] tmrCount   = '0;
    logic        tmrRun     = 1'b0;
    logic        tmrTo      = 1'b0;
    logic        tmrIto     = 1'b0;

    wire [20:0] busVec = {avm_chipselect, avm_write_n, avm_address, avm_writedata};

    always #5 clk = ~clk;

    soc_timer_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_period(req_period), .cancel(cancel),
        .accept(accept), .done(done), .aborted(aborted), .busy(busy), .owner_id(owner_id),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata), .avm_irq(avm_irq)
    );

    // Behavioural timer: one-shot countdown of period+1 cycles, TO sticky until status write
    assign avm_irq = (tmrTo && tmrIto) || irqForce;

    always @(posedge clk) begin
        if (stopModel) begin
            tmrRun <= 1'b0;
        end else if (tmrRun) begin
            if (tmrCount == 32'd0) begin
                tmrTo  <= 1'b1;
                tmrRun <= 1'b0;
            end else begin
                tmrCount <= tmrCount - 32'd1;
            end
        end
        if (avm_chipselect && !avm_write_n) begin
            case (avm_address)
                3'd0: tmrTo <= 1'b0;
                3'd1: begin
                    tmrIto <= avm_writedata[0];
                    if (avm_writedata[3]) begin
                        tmrRun <= 1'b0;
                    end else if (avm_writedata[2]) begin
                        tmrRun   <= 1'b1;
                        tmrCount <= {tmrPeriodH, tmrPeriodL};
                    end
                end
                3'd2: tmrPeriodL <= avm_writedata;
                3'd3: tmrPeriodH <= avm_writedata;
                default: ;
            endcase
        end
    end

    function automatic logic [20:0] busWr(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, 1'b0, a, d};
    endfunction

    // Reset state of all outputs
    task automatic test_reset();
        reset_n = 1'b0;
        req = '0;
        cancel = '0;
        req_period = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (owner_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_owner: got %0d expected 0", owner_id); end
        checks++; if (busVec !== BUS_IDLE) begin errors++; $display("[TB] FAIL reset_bus: got %h expected %h", busVec, BUS_IDLE); end
        checks++; if ({accept, done, aborted} !== 12'd0) begin errors++; $display("[TB] FAIL reset_pulses: got %h expected 000", {accept, done, aborted}); end
        reset_n = 1'b1;
    endtask

    // Single delay of 100 cycles on requester 0
    task automatic test_basic();
        int n;
        @(negedge clk);
        req_period[31:0] = 32'd100;
        req = 4'b0001;
        #1;
        checks++; if (accept !== 4'b0001) begin errors++; $display("[TB] FAIL basic_accept: got %b expected 0001", accept); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_pre: got %b expected 0", busy); end
        @(negedge clk); req = '0; #1;
        checks++; if (busVec !== busWr(3'd0, 16'd0)) begin errors++; $display("[TB] FAIL basic_clr: got %h expected %h", busVec, busWr(3'd0, 16'd0)); end
        checks++; if (busy !== 1'b1 || owner_id !== 2'd0) begin errors++; $display("[TB] FAIL basic_busy_owner: got %b/%0d expected 1/0", busy, owner_id); end
        @(negedge clk); #1;
        checks++; if (busVec !== busWr(3'd2, 16'd99)) begin errors++; $display("[TB] FAIL basic_wpl: got %h expected %h", busVec, busWr(3'd2, 16'd99)); end
        @(negedge clk); #1;
        checks++; if (busVec !== busWr(3'd3, 16'd0)) begin errors++; $display("[TB] FAIL basic_wph: got %h expected %h", busVec, busWr(3'd3, 16'd0)); end
        @(negedge clk); #1;
        checks++; if (busVec !== BUS_IDLE) begin errors++; $display("[TB] FAIL basic_gap: got %h expected %h", busVec, BUS_IDLE); end
        @(negedge clk); #1;
        checks++; if (busVec !== busWr(3'd1, 16'h0005)) begin errors++; $display("[TB] FAIL basic_wctl: got %h expected %h", busVec, busWr(3'd1, 16'h0005)); end
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (done === 4'b0000 && n < 300);
        checks++; if (done !== 4'b0001) begin errors++; $display("[TB] FAIL basic_done: got %b expected 0001 after %0d cycles", done, n); end
        checks++; if (n < 100 || n > 104) begin errors++; $display("[TB] FAIL basic_expiry_time: got %0d cycles expected 100..104", n); end
        checks++; if (busVec !== busWr(3'd0, 16'd0) || aborted !== 4'b0000) begin errors++; $display("[TB] FAIL basic_ack: got %h/%b expected %h/0000", busVec, aborted, busWr(3'd0, 16'd0)); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 4'b0000) begin errors++; $display("[TB] FAIL basic_idle: got %b/%b expected 0/0000", busy, done); end
    endtask

    // All requesters held: grants rotate 0,1,2,3 then wrap to 0
    task automatic test_round_robin();
        int expSeq[5] = '{0, 1, 2, 3, 0};
        logic [3:0] expOh;
        int n;
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) req_period[32*i +: 32] = 32'd3;
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            expOh = 4'b0001 << expSeq[j];
            n = 0;
            #1;
            while (accept === 4'b0000 && n < 60) begin
                @(negedge clk); #1; n++;
            end
            checks++; if (accept !== expOh) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", j, accept, expOh); end
            @(negedge clk);
        end
        req = '0;
        n = 0;
        #1;
        while (done === 4'b0000 && n < 60) begin
            @(negedge clk); #1; n++;
        end
        checks++; if (done !== 4'b0001) begin errors++; $display("[TB] FAIL rr_last_done: got %b expected 0001", done); end
        @(negedge clk);
    endtask

    // Period split across two 16-bit writes, then non-owner and owner cancel
    task automatic test_period_split_cancel();
        req_period[95:64] = 32'h0001_0000;
        req = 4'b0100;
        #1;
        checks++; if (accept !== 4'b0100) begin errors++; $display("[TB] FAIL split_accept: got %b expected 0100", accept); end
        @(negedge clk); req = '0; #1;
        checks++; if (owner_id !== 2'd2) begin errors++; $display("[TB] FAIL split_owner: got %0d expected 2", owner_id); end
        @(negedge clk); #1;
        checks++; if (busVec !== busWr(3'd2, 16'hFFFF)) begin errors++; $display("[TB] FAIL split_wpl: got %h expected %h", busVec, busWr(3'd2, 16'hFFFF)); end
        @(negedge clk); #1;
        checks++; if (busVec !== busWr(3'd3, 16'h0000)) begin errors++; $display("[TB] FAIL split_wph: got %h expected %h", busVec, busWr(3'd3, 16'h0000)); end
        repeat (3) @(negedge clk);
        cancel = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (busVec !== BUS_IDLE || aborted !== 4'b0000 || busy !== 1'b1) begin errors++; $display("[TB] FAIL cancel_other%0d: got %h/%b/%b expected %h/0000/1", i, busVec, aborted, busy, BUS_IDLE); end
        end
        cancel = 4'b0100;
        @(negedge clk); cancel = '0; #1;
        checks++; if (busVec !== busWr(3'd1, 16'h0008)) begin errors++; $display("[TB] FAIL cancel_stop: got %h expected %h", busVec, busWr(3'd1, 16'h0008)); end
        @(negedge clk); #1;
        checks++; if (busVec !== busWr(3'd0, 16'd0)) begin errors++; $display("[TB] FAIL cancel_ack: got %h expected %h", busVec, busWr(3'd0, 16'd0)); end
        checks++; if (aborted !== 4'b0100 || done !== 4'b0000) begin errors++; $display("[TB] FAIL cancel_pulse: got %b/%b expected 0100/0000", aborted, done); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0 || aborted !== 4'b0000) begin errors++; $display("[TB] FAIL cancel_idle: got %b/%b expected 0/0000", busy, aborted); end
    endtask

    // Periods 0 and 1 both load 0
    task automatic test_period_zero_one();
        int n;
        for (int p = 0; p < 2; p++) begin
            req_period[63:32] = 32'(p);
            req = 4'b0010;
            #1;
            checks++; if (accept !== 4'b0010) begin errors++; $display("[TB] FAIL p%0d_accept: got %b expected 0010", p, accept); end
            @(negedge clk); req = '0;
            @(negedge clk); #1;
            checks++; if (busVec !== busWr(3'd2, 16'd0)) begin errors++; $display("[TB] FAIL p%0d_wpl: got %h expected %h", p, busVec, busWr(3'd2, 16'd0)); end
            @(negedge clk); #1;
            checks++; if (busVec !== busWr(3'd3, 16'd0)) begin errors++; $display("[TB] FAIL p%0d_wph: got %h expected %h", p, busVec, busWr(3'd3, 16'd0)); end
            n = 0;
            while (done === 4'b0000 && n < 30) begin
                @(negedge clk); #1; n++;
            end
            checks++; if (done !== 4'b0010) begin errors++; $display("[TB] FAIL p%0d_done: got %b expected 0010", p, done); end
            @(negedge clk);
        end
    endtask

    // irq and owner cancel in the same WAIT cycle: completion wins, no STOP write
    task automatic test_irq_cancel_same();
        req_period[127:96] = 32'h0000_1000;
        req = 4'b1000;
        #1;
        checks++; if (accept !== 4'b1000) begin errors++; $display("[TB] FAIL same_accept: got %b expected 1000", accept); end
        @(negedge clk); req = '0;
        repeat (6) @(negedge clk);
        irqForce = 1'b1;
        cancel = 4'b1000;
        @(negedge clk); #1;
        checks++; if (busVec !== busWr(3'd0, 16'd0)) begin errors++; $display("[TB] FAIL same_ack_bus: got %h expected %h", busVec, busWr(3'd0, 16'd0)); end
        checks++; if (done !== 4'b1000 || aborted !== 4'b0000) begin errors++; $display("[TB] FAIL same_pulse: got %b/%b expected 1000/0000", done, aborted); end
        irqForce = 1'b0;
        cancel = '0;
        stopModel = 1'b1;
        @(negedge clk); #1;
        stopModel = 1'b0;
        checks++; if (busy !== 1'b0 || {done, aborted} !== 8'd0) begin errors++; $display("[TB] FAIL same_idle: got %b/%h expected 0/00", busy, {done, aborted}); end
    endtask

    // Reset during WPH abandons the sequence; a new request starts cleanly
    task automatic test_reset_midseq();
        int n;
        @(negedge clk);
        req_period[31:0] = 32'd50;
        req = 4'b0001;
        #1;
        checks++; if (accept !== 4'b0001) begin errors++; $display("[TB] FAIL mid_accept: got %b expected 0001", accept); end
        @(negedge clk); req = '0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (busVec !== busWr(3'd3, 16'd0)) begin errors++; $display("[TB] FAIL mid_wph: got %h expected %h", busVec, busWr(3'd3, 16'd0)); end
        reset_n = 1'b0;
        @(negedge clk); #1;
        checks++; if (busVec !== BUS_IDLE) begin errors++; $display("[TB] FAIL mid_bus_idle: got %h expected %h", busVec, BUS_IDLE); end
        checks++; if (busy !== 1'b0 || owner_id !== 2'd0 || {accept, done, aborted} !== 12'd0) begin errors++; $display("[TB] FAIL mid_reset_state: got %b/%0d/%h expected 0/0/000", busy, owner_id, {accept, done, aborted}); end
        reset_n = 1'b1;
        req_period[63:32] = 32'd2;
        req = 4'b0010;
        #1;
        checks++; if (accept !== 4'b0010) begin errors++; $display("[TB] FAIL mid_reaccept: got %b expected 0010", accept); end
        @(negedge clk); req = '0; #1;
        checks++; if (busVec !== busWr(3'd0, 16'd0) || busy !== 1'b1 || owner_id !== 2'd1) begin errors++; $display("[TB] FAIL mid_restart_clr: got %h/%b/%0d expected %h/1/1", busVec, busy, owner_id, busWr(3'd0, 16'd0)); end
        n = 0;
        while (done === 4'b0000 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        checks++; if (done !== 4'b0010) begin errors++; $display("[TB] FAIL mid_done: got %b expected 0010", done); end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        req = '0;
        cancel = '0;
        req_period = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_period_split_cancel();
        test_period_zero_one();
        test_irq_cancel_same();
        test_reset_midseq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
